// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle MULTU/DIVU controller.
//   MD_WIDTH    : default datapath width (operands, HI, LO, ALU)
//   ALU_*       : ALU control encodings, shared with the ALU control decoder
//   md_state_t  : sequencer state encoding. NEG_A/NEG_B/FIX_LO/FIX_HI are only
//                 reachable when MULDIV_SIGNED_EN is defined.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    MD_IDLE   = 3'd0,
    MD_NEG_A  = 3'd1,
    MD_NEG_B  = 3'd2,
    MD_ITER   = 3'd3,
    MD_FIX_LO = 3'd4,
    MD_FIX_HI = 3'd5,
    MD_DONE   = 3'd6
  } md_state_t;

endpackage

// File: rtl/muldiv_acc.sv
// HI/LO accumulator and operand storage for muldiv_sequencer.
// Holds HI, LO, the second operand (multiplicand or divisor) and the op type,
// and computes their next values from the current sequencer state and the
// shared ALU's result.
//   clk, rst            : clock, synchronous active-high reset
//   state               : current sequencer state
//   accept              : a new operation is being accepted this cycle
//   op_div, op_signed   : op type, sampled with accept
//   src_a, src_b        : operands, sampled with accept
//   alu_result, alu_cout: shared ALU outputs for this cycle
//   hi, lo              : accumulator outputs
//   opb                 : multiplicand (multiply) or divisor (divide)
//   shift_hi            : upper word of {hi,lo}<<1, the divide step's ALU A operand
//   md_div              : latched op type
//   fix_cin             : +1 term for FIX_HI (low-word carry, or 1 for remainders)
// Optional feature: MULDIV_SIGNED_EN adds operand and result sign handling.
module muldiv_acc
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  md_state_t        state,
  input  logic             accept,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] shift_hi,
  output logic             md_div,
  output logic             fix_cin
);

  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic             div_reg, div_next;

  assign hi       = hi_reg;
  assign lo       = lo_reg;
  assign opb      = opb_reg;
  assign md_div   = div_reg;
  assign shift_hi = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};

`ifdef MULDIV_SIGNED_EN
  logic sgn_reg, sgn_next;
  logic sa_reg, sa_next;
  logic sb_reg, sb_next;
  logic carry_reg, carry_next;
  logic neg_a, neg_b, neg_lo, neg_hi;

  // Operands are made positive, the unsigned core runs, then the result is
  // re-signed: product/quotient take sa^sb, the remainder takes sa.
  assign neg_a   = sgn_reg & sa_reg;
  assign neg_b   = sgn_reg & sb_reg;
  assign neg_lo  = sgn_reg & (sa_reg ^ sb_reg);
  assign neg_hi  = sgn_reg & (div_reg ? sa_reg : (sa_reg ^ sb_reg));
  // A 64-bit product negates as {~hi + (lo==0), -lo}; a remainder is a
  // standalone word so it always gets +1.
  assign fix_cin = div_reg ? 1'b1 : carry_reg;
`else
  logic unused_signed;
  assign unused_signed = op_signed;
  assign fix_cin       = 1'b0;
`endif

  always_comb begin
    hi_next  = hi_reg;
    lo_next  = lo_reg;
    opb_next = opb_reg;
    div_next = div_reg;
`ifdef MULDIV_SIGNED_EN
    sgn_next   = sgn_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    carry_next = carry_reg;
`endif
    if (accept) begin
      // LO carries the operand that gets shifted (multiplier / dividend);
      // the other operand parks in opb.
      div_next = op_div;
      hi_next  = '0;
      lo_next  = op_div ? src_a : src_b;
      opb_next = op_div ? src_b : src_a;
      if (op_div && (src_b == '0)) begin
        hi_next = src_a;
        lo_next = '1;
      end
`ifdef MULDIV_SIGNED_EN
      sgn_next = op_signed;
      sa_next  = src_a[WIDTH-1];
      sb_next  = src_b[WIDTH-1];
`endif
    end else begin
      case (state)
        MD_ITER: begin
          if (div_reg) begin
            // hi[MSB] is the shifted-out 33rd remainder bit: when set the
            // partial remainder exceeds any divisor, so always subtract.
            if (hi_reg[WIDTH-1] | alu_cout) begin
              hi_next = alu_result;
              lo_next = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              hi_next = shift_hi;
              lo_next = {lo_reg[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_next = {alu_cout, alu_result[WIDTH-1:1]};
            lo_next = {alu_result[0], lo_reg[WIDTH-1:1]};
          end
        end
`ifdef MULDIV_SIGNED_EN
        MD_NEG_A: begin
          if (neg_a) begin
            if (div_reg) lo_next  = alu_result;
            else         opb_next = alu_result;
          end
        end
        MD_NEG_B: begin
          if (neg_b) begin
            if (div_reg) opb_next = alu_result;
            else         lo_next  = alu_result;
          end
        end
        MD_FIX_LO: begin
          if (neg_lo) lo_next = alu_result;
          carry_next = alu_cout;  // 0 - lo has no borrow only when lo == 0
        end
        MD_FIX_HI: begin
          if (neg_hi) hi_next = alu_result;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg  <= '0;
      lo_reg  <= '0;
      opb_reg <= '0;
      div_reg <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_reg   <= 1'b0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      carry_reg <= 1'b0;
`endif
    end else begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      opb_reg <= opb_next;
      div_reg <= div_next;
`ifdef MULDIV_SIGNED_EN
      sgn_reg   <= sgn_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      carry_reg <= carry_next;
`endif
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller for the EX stage. Time-shares the 32-bit
// ALU one add/subtract per cycle; HI/LO live in muldiv_acc.
//   clk, rst             : clock, synchronous active-high reset
//   start, op_div        : one-cycle request and op type (0 mul, 1 div)
//   op_signed            : signed request (honoured only with MULDIV_SIGNED_EN)
//   kill                 : pipeline flush, aborts without a done pulse
//   src_a, src_b         : multiplicand/dividend, multiplier/divisor
//   alu_a, alu_b, alu_ctrl: ALU drive (AND of zeros when not stepping)
//   alu_result, alu_cout : combinational ALU response
//   busy                 : operation in progress (low in IDLE and DONE)
//   done                 : one-cycle pulse, hi/lo valid from here on
//   hi, lo               : product high/low or remainder/quotient
// Optional feature: MULDIV_SIGNED_EN adds NEG_A/NEG_B before ITER and
// FIX_LO/FIX_HI after it; latency becomes ITERS+5 for every op.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             kill,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  md_state_t        state_reg, state_next;
  logic [CW-1:0]    step_reg, step_next;
  logic             accept, div_zero, last_step;
  logic [WIDTH-1:0] opb, shift_hi;
  logic             md_div, fix_cin;

  assign accept    = start && (state_reg == MD_IDLE) && !kill;
  assign div_zero  = op_div && (src_b == '0);
  assign last_step = (step_reg == CW'(ITERS - 1));

  assign busy = (state_reg != MD_IDLE) && (state_reg != MD_DONE);
  assign done = (state_reg == MD_DONE);

`ifndef MULDIV_SIGNED_EN
  logic unused_fix_cin;
  assign unused_fix_cin = fix_cin;
`endif

  muldiv_acc #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .state      (state_reg),
    .accept     (accept),
    .op_div     (op_div),
    .op_signed  (op_signed),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .hi         (hi),
    .lo         (lo),
    .opb        (opb),
    .shift_hi   (shift_hi),
    .md_div     (md_div),
    .fix_cin    (fix_cin)
  );

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    case (state_reg)
      MD_IDLE: begin
        if (accept) begin
          step_next = '0;
          // Divide by zero has a fixed answer loaded at accept time.
          if (div_zero) begin
            state_next = MD_DONE;
          end else begin
`ifdef MULDIV_SIGNED_EN
            state_next = MD_NEG_A;
`else
            state_next = MD_ITER;
`endif
          end
        end
      end
`ifdef MULDIV_SIGNED_EN
      MD_NEG_A:  state_next = MD_NEG_B;
      MD_NEG_B:  state_next = MD_ITER;
      MD_FIX_LO: state_next = MD_FIX_HI;
      MD_FIX_HI: state_next = MD_DONE;
`endif
      MD_ITER: begin
        step_next = step_reg + 1'b1;
        if (last_step) begin
`ifdef MULDIV_SIGNED_EN
          state_next = MD_FIX_LO;
`else
          state_next = MD_DONE;
`endif
        end
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (kill) state_next = MD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MD_IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  // ALU port mux: the ALU sees zeros and AND whenever no step is running.
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_AND;
    case (state_reg)
      MD_ITER: begin
        if (md_div) begin
          alu_a    = shift_hi;
          alu_b    = opb;
          alu_ctrl = ALU_SUB;
        end else begin
          alu_a    = hi;
          alu_b    = lo[0] ? opb : '0;
          alu_ctrl = ALU_ADD;
        end
      end
`ifdef MULDIV_SIGNED_EN
      // src_a sits in LO for divides and in opb for multiplies; src_b the reverse.
      MD_NEG_A: begin
        alu_b    = md_div ? lo : opb;
        alu_ctrl = ALU_SUB;
      end
      MD_NEG_B: begin
        alu_b    = md_div ? opb : lo;
        alu_ctrl = ALU_SUB;
      end
      MD_FIX_LO: begin
        alu_b    = lo;
        alu_ctrl = ALU_SUB;
      end
      MD_FIX_HI: begin
        alu_a    = ~hi;
        alu_b    = {{(WIDTH-1){1'b0}}, fix_cin};
        alu_ctrl = ALU_ADD;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: models the ALU, issues directed and random
// multiply/divide requests, and checks every done pulse against a queue of
// results computed with plain integer arithmetic.
module tb_muldiv_sequencer;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  localparam int LAT = SIGNED_EN ? 37 : 33;

  logic        clk = 1'b0;
  logic        rst, start, op_div, op_signed, kill;
  logic [31:0] src_a, src_b, alu_a, alu_b, alu_result, hi, lo;
  logic [2:0]  alu_ctrl;
  logic        alu_cout, busy, done;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   next_id = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU: ADD, SUB (carry = no borrow), AND otherwise.
  always_comb begin
    case (alu_ctrl)
      3'b010:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: begin
        alu_result = alu_a & alu_b;
        alu_cout   = 1'b0;
      end
    endcase
  end

  muldiv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_div     (op_div),
    .op_signed  (op_signed),
    .kill       (kill),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic.
  function automatic void ref_model(input bit div, input bit sgn,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] ehi, output logic [31:0] elo,
                                    output int lat);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    lat = LAT;
    if (div && b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
      lat = 1;
    end else if (sgn && SIGNED_EN) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (div) begin
        q = sa / sbv;
        r = sa % sbv;
        elo = q[31:0];
        ehi = r[31:0];
      end else begin
        p = sa * sbv;
        ehi = p[63:32];
        elo = p[31:0];
      end
    end else begin
      if (div) begin
        elo = a / b;
        ehi = a % b;
      end else begin
        p = {32'd0, a} * {32'd0, b};
        ehi = p[63:32];
        elo = p[31:0];
      end
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("op%0d_done_cycle", mon_e.id), 64'(cyc), 64'(mon_e.done_cyc));
        chk($sformatf("op%0d_hi", mon_e.id), 64'(hi), 64'(mon_e.hi));
        chk($sformatf("op%0d_lo", mon_e.id), 64'(lo), 64'(mon_e.lo));
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of cycle 1.
  task automatic issue(input bit div, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] ehi, elo;
    int          lat;
    ref_model(div, sgn, a, b, ehi, elo, lat);
    e.hi = ehi;
    e.lo = elo;
    e.done_cyc = cyc + lat;
    e.id = next_id;
    next_id++;
    sb.push_back(e);
    $display("op%0d: %s%s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h",
             e.id, div ? "DIV" : "MUL", sgn ? "S" : "U", a, b, ehi, elo);
    start = 1'b1; op_div = div; op_signed = sgn; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op_signed = 1'b0;
    src_a = $urandom; src_b = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("completion_outstanding", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) begin
      sb.delete();
      do_reset();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'd0);
    chk({tag, "_lo"}, 64'(lo), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    bit          rdiv, rsgn;
    rst = 1'b1; start = 1'b0; op_div = 1'b0; op_signed = 1'b0; kill = 1'b0;
    src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Max unsigned product with cycle-exact busy.
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= LAT; k++) begin
      chk($sformatf("mul_busy_c%0d", k), 64'(busy), 64'(k <= LAT - 1));
      if (k < LAT) @(negedge clk);
    end
    wait_idle();

    issue(1'b1, 1'b0, 32'd100, 32'd7);
    wait_idle();
    issue(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    wait_idle();

    // Divide by zero: done in cycle 1, ALU never asked to subtract.
    issue(1'b1, 1'b0, 32'd5, 32'd0);
    chk("div0_alu_ctrl", 64'(alu_ctrl), 64'd0);
    wait_idle();

    // start during a running op is ignored.
    issue(1'b0, 1'b0, $urandom, $urandom);
    repeat (9) @(negedge clk);
    start = 1'b1; op_div = 1'b1; src_a = 32'd9; src_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // kill at cycle 15, then immediate restart.
    issue(1'b0, 1'b0, $urandom, $urandom);
    repeat (14) @(negedge clk);
    kill = 1'b1;
    sb.delete();
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", 64'(busy), 64'd0);
    chk("kill_done", 64'(done), 64'd0);
    issue(1'b1, 1'b0, 32'd1000, 32'd33);
    wait_idle();

    // kill with start drops the request.
    start = 1'b1; kill = 1'b1; op_div = 1'b0; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("killstart_busy", 64'(busy), 64'd0);
    chk("killstart_done", 64'(done), 64'd0);
    @(negedge clk);

    // rst at cycle 20.
    issue(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);

    // Signed requests (unsigned results when the feature is not built in).
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4);
    wait_idle();

    for (int n = 0; n < 24; n++) begin
      rdiv = 1'($urandom_range(0, 1));
      rsgn = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 255));
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(rdiv, rsgn, ra, rb);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
